// File: rtl/udp_tx_pkg.sv
// Shared UDP framing constants, FSM encoding and byte-enable helper for udp_tx.
package udp_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [7:0]  UDP_PROTO       = 8'd17;
    localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
    localparam logic [15:0] UDP_MAX_PAYLOAD = 16'd1472;
    localparam logic [2:0]  IP_FLAG_DF      = 3'b010;

    function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/udp_tx.sv
// UDP transmit framer: prepends the 8-byte UDP header and tags every beat with IP_TX metadata.
// Header one cycle after frame start, payload one registered cycle; upstream stalls while the output beat is held.
module udp_tx
    import udp_tx_pkg::*;
#(
    parameter logic [15:0] P_SRC_PORT = 16'd8080,
    parameter logic [15:0] P_DST_PORT = 16'd8080
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_dynamic_src_port,
    input  logic        i_dynamic_src_valid,
    input  logic [15:0] i_dynamic_dst_port,
    input  logic        i_dynamic_dst_valid,
    input  logic [63:0] s_axis_user_data,
    input  logic [15:0] s_axis_user_user,
    input  logic [7:0]  s_axis_user_keep,
    input  logic        s_axis_user_last,
    input  logic        s_axis_user_valid,
    output logic        s_axis_user_ready,
    output logic [63:0] m_axis_ip_data,
    output logic [55:0] m_axis_ip_user,
    output logic [7:0]  m_axis_ip_keep,
    output logic        m_axis_ip_last,
    output logic        m_axis_ip_valid,
    input  logic        m_axis_ip_ready,
    output logic        o_drop_pulse,
    output logic        o_len_err
);

    state_t      state, state_nxt;
    logic [15:0] src_port, dst_port;
    logic [15:0] pay_len;
    logic [15:0] id_q;
    logic [15:0] byte_cnt;
    logic        in_done;
    logic        err_seen;

    logic        len_ok;
    logic        in_acc;
    logic        out_acc;
    logic [15:0] cnt_nxt;
    logic [15:0] hdr_len_new;
    logic [15:0] dgram_len;

    assign len_ok      = (s_axis_user_user != 16'd0) && (s_axis_user_user <= UDP_MAX_PAYLOAD);
    assign in_acc      = s_axis_user_valid && s_axis_user_ready;
    assign out_acc     = m_axis_ip_valid && m_axis_ip_ready;
    assign cnt_nxt     = byte_cnt + {12'd0, keep_bytes(s_axis_user_keep)};
    assign hdr_len_new = s_axis_user_user + UDP_HDR_LEN;
    assign dgram_len   = pay_len + UDP_HDR_LEN;

    // Metadata is derived from per-datagram registers so it stays constant across all beats.
    assign m_axis_ip_user = m_axis_ip_valid ? {dgram_len, IP_FLAG_DF, UDP_PROTO, 13'd0, id_q} : 56'd0;

    always_comb begin
        state_nxt         = state;
        s_axis_user_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_axis_user_valid) begin
                    state_nxt = len_ok ? ST_HEAD : ST_DROP;
                end
            end
            ST_HEAD: begin
                if (out_acc) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // Once last is taken, hold off the next frame until this one drains downstream.
                s_axis_user_ready = !in_done && (!m_axis_ip_valid || m_axis_ip_ready);
                if (out_acc && m_axis_ip_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_axis_user_ready = 1'b1;
                if (s_axis_user_valid && s_axis_user_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            src_port        <= P_SRC_PORT;
            dst_port        <= P_DST_PORT;
            pay_len         <= 16'd0;
            id_q            <= 16'd0;
            byte_cnt        <= 16'd0;
            in_done         <= 1'b0;
            err_seen        <= 1'b0;
            m_axis_ip_data  <= 64'd0;
            m_axis_ip_keep  <= 8'd0;
            m_axis_ip_last  <= 1'b0;
            m_axis_ip_valid <= 1'b0;
            o_drop_pulse    <= 1'b0;
            o_len_err       <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_drop_pulse <= 1'b0;
            o_len_err    <= 1'b0;
            if (i_dynamic_src_valid) begin
                src_port <= i_dynamic_src_port;
            end
            if (i_dynamic_dst_valid) begin
                dst_port <= i_dynamic_dst_port;
            end
            case (state)
                ST_IDLE: begin
                    if (s_axis_user_valid) begin
                        pay_len  <= s_axis_user_user;
                        byte_cnt <= 16'd0;
                        in_done  <= 1'b0;
                        err_seen <= 1'b0;
                        if (len_ok) begin
                            m_axis_ip_data  <= {src_port, dst_port, hdr_len_new, 16'h0000};
                            m_axis_ip_keep  <= 8'hFF;
                            m_axis_ip_last  <= 1'b0;
                            m_axis_ip_valid <= 1'b1;
                        end
                    end
                end
                ST_HEAD: begin
                    if (out_acc) begin
                        m_axis_ip_valid <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (in_acc) begin
                        m_axis_ip_data  <= s_axis_user_data;
                        m_axis_ip_keep  <= s_axis_user_keep;
                        m_axis_ip_last  <= s_axis_user_last;
                        m_axis_ip_valid <= 1'b1;
                        byte_cnt        <= cnt_nxt;
                        if (s_axis_user_last) begin
                            in_done <= 1'b1;
                        end
                        if (!err_seen && (s_axis_user_last ? (cnt_nxt != pay_len) : (cnt_nxt >= pay_len))) begin
                            o_len_err <= 1'b1;
                            err_seen  <= 1'b1;
                        end
                    end else if (out_acc) begin
                        m_axis_ip_valid <= 1'b0;
                    end
                    if (out_acc && m_axis_ip_last) begin
                        id_q <= id_q + 16'd1;
                    end
                end
                ST_DROP: begin
                    if (s_axis_user_valid && s_axis_user_last) begin
                        o_drop_pulse <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx.sv
// Directed bench for udp_tx: table of frames checked by an output scoreboard, plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_udp_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dyn_src_port, dyn_dst_port;
    logic        dyn_src_vld, dyn_dst_vld;
    logic [63:0] s_data;
    logic [15:0] s_user;
    logic [7:0]  s_keep;
    logic        s_last, s_valid, s_ready;
    logic [63:0] m_data;
    logic [55:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last, m_valid;
    logic        m_ready = 1'b1;
    logic        drop_pulse, len_err;

    always #5 clk = ~clk;

    udp_tx dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_dynamic_src_port  (dyn_src_port),
        .i_dynamic_src_valid (dyn_src_vld),
        .i_dynamic_dst_port  (dyn_dst_port),
        .i_dynamic_dst_valid (dyn_dst_vld),
        .s_axis_user_data    (s_data),
        .s_axis_user_user    (s_user),
        .s_axis_user_keep    (s_keep),
        .s_axis_user_last    (s_last),
        .s_axis_user_valid   (s_valid),
        .s_axis_user_ready   (s_ready),
        .m_axis_ip_data      (m_data),
        .m_axis_ip_user      (m_user),
        .m_axis_ip_keep      (m_keep),
        .m_axis_ip_last      (m_last),
        .m_axis_ip_valid     (m_valid),
        .m_axis_ip_ready     (m_ready),
        .o_drop_pulse        (drop_pulse),
        .o_len_err           (len_err)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [55:0] user;
    } beat_t;

    typedef struct {
        int          len;
        int          nbytes;
        bit          toggle;
        bit          fwd;
        logic [15:0] hdr_len;
        int          drops;
        int          errs;
    } vec_t;

    beat_t       exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          beats_seen = 0;
    int          drop_cnt = 0;
    int          err_cnt = 0;
    int          fid = 0;
    bit          rdy_toggle = 1'b0;
    bit          abort = 1'b0;
    logic [15:0] exp_src = 16'd8080;
    logic [15:0] exp_dst = 16'd8080;
    logic [15:0] exp_id = 16'd0;
    logic        stall_prev = 1'b0;
    logic [159:0] prev_vec = '0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = rdy_toggle ? ~m_ready : 1'b1;
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stable_while_stalled", {m_valid, m_last, m_keep, m_data, m_user}, prev_vec);
            end
            if (m_valid && m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_keep_last_user", {m_keep, m_last, m_user}, {e.keep, e.last, e.user});
                end
            end
            if (drop_pulse) drop_cnt++;
            if (len_err) err_cnt++;
            stall_prev = m_valid && !m_ready;
            prev_vec = {m_valid, m_last, m_keep, m_data, m_user};
        end
    end

    task automatic send_frame(input int len, input int nbytes, input bit fwd, input logic [15:0] hdr_len);
        int    nb;
        int    rem;
        int    waited;
        bit    got;
        beat_t b;
        nb = (nbytes + 7) / 8;
        fid++;
        if (fwd) begin
            b.data = {exp_src, exp_dst, hdr_len, 16'h0000};
            b.keep = 8'hFF;
            b.last = 1'b0;
            b.user = {hdr_len, 3'b010, 8'd17, 13'd0, exp_id};
            exp_q.push_back(b);
        end
        for (int i = 0; i < nb; i++) begin
            rem = nbytes - 8 * i;
            s_valid = 1'b1;
            s_user  = 16'(len);
            s_data  = {8'hD0, 8'(fid), 16'(i), 32'h5A5A_0000 + 32'(i)};
            s_keep  = (rem >= 8) ? 8'hFF : 8'(8'hFF << (8 - rem));
            s_last  = (i == nb - 1);
            if (fwd) begin
                b.data = s_data;
                b.keep = s_keep;
                b.last = s_last;
                b.user = {hdr_len, 3'b010, 8'd17, 13'd0, exp_id};
                exp_q.push_back(b);
            end
            got = 1'b0;
            waited = 0;
            while (!got) begin
                @(negedge clk);
                if (abort) begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    return;
                end
                if (s_ready) got = 1'b1;
                else if (++waited > 2000) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL input_ready_timeout: got no ready after %0d cycles, expected ready", waited);
                    s_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (fwd) exp_id = exp_id + 16'd1;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while ((exp_q.size() != 0 || m_valid) && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        int   d0, e0, b0, nb;

        vecs[0] = '{len: 16,   nbytes: 16,   toggle: 0, fwd: 1, hdr_len: 16'h0018, drops: 0, errs: 0};
        vecs[1] = '{len: 11,   nbytes: 11,   toggle: 0, fwd: 1, hdr_len: 16'h0013, drops: 0, errs: 0};
        vecs[2] = '{len: 64,   nbytes: 64,   toggle: 1, fwd: 1, hdr_len: 16'h0048, drops: 0, errs: 0};
        vecs[3] = '{len: 0,    nbytes: 8,    toggle: 0, fwd: 0, hdr_len: 16'h0000, drops: 1, errs: 0};
        vecs[4] = '{len: 1500, nbytes: 20,   toggle: 0, fwd: 0, hdr_len: 16'h0000, drops: 1, errs: 0};
        vecs[5] = '{len: 8,    nbytes: 8,    toggle: 1, fwd: 1, hdr_len: 16'h0010, drops: 0, errs: 0};
        vecs[6] = '{len: 16,   nbytes: 8,    toggle: 0, fwd: 1, hdr_len: 16'h0018, drops: 0, errs: 1};
        vecs[7] = '{len: 8,    nbytes: 16,   toggle: 0, fwd: 1, hdr_len: 16'h0010, drops: 0, errs: 1};
        vecs[8] = '{len: 1472, nbytes: 1472, toggle: 0, fwd: 1, hdr_len: 16'h05C8, drops: 0, errs: 0};
        vecs[9] = '{len: 1473, nbytes: 8,    toggle: 1, fwd: 0, hdr_len: 16'h0000, drops: 1, errs: 0};

        rst = 1'b1;
        dyn_src_port = 16'd0; dyn_dst_port = 16'd0;
        dyn_src_vld = 1'b0;   dyn_dst_vld = 1'b0;
        s_data = '0; s_user = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s_ready", s_ready, 1'b0);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_m_outputs", {m_data, m_user, m_keep, m_last}, '0);
        check("reset_pulses", {drop_pulse, len_err}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            d0 = drop_cnt; e0 = err_cnt; b0 = beats_seen;
            rdy_toggle = vecs[v].toggle;
            send_frame(vecs[v].len, vecs[v].nbytes, vecs[v].fwd, vecs[v].hdr_len);
            wait_idle();
            rdy_toggle = 1'b0;
            nb = vecs[v].fwd ? (vecs[v].nbytes + 7) / 8 + 1 : 0;
            check($sformatf("vec%0d_beats", v), beats_seen - b0, nb);
            check($sformatf("vec%0d_drop_pulses", v), drop_cnt - d0, vecs[v].drops);
            check($sformatf("vec%0d_len_err_pulses", v), err_cnt - e0, vecs[v].errs);
        end

        // Destination port strobed while a frame is in flight only affects the next header.
        fork
            send_frame(32, 32, 1'b1, 16'h0028);
            begin
                repeat (3) @(posedge clk);
                #1;
                dyn_dst_port = 16'd5000;
                dyn_dst_vld  = 1'b1;
                @(posedge clk);
                #1 dyn_dst_vld = 1'b0;
            end
        join
        wait_idle();
        exp_dst = 16'h1388;
        send_frame(8, 8, 1'b1, 16'h0010);
        wait_idle();

        // ID wrap from 16'hFFFF.
        @(negedge clk);
        force dut.id_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.id_q;
        exp_id = 16'hFFFF;
        send_frame(8, 8, 1'b1, 16'h0010);
        wait_idle();
        send_frame(8, 8, 1'b1, 16'h0010);
        wait_idle();

        // Reset in the middle of payload: output abandoned, ID and ports back to defaults.
        fork
            send_frame(64, 64, 1'b1, 16'h0048);
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("pre_reset_valid", m_valid, 1'b1);
                @(posedge clk);
                #1;
                rst = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("post_reset_valid", m_valid, 1'b0);
                check("post_reset_ready", s_ready, 1'b0);
            end
        join
        @(posedge clk);
        #1;
        rst = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        exp_id = 16'd0;
        exp_src = 16'd8080;
        exp_dst = 16'd8080;
        b0 = beats_seen;
        send_frame(8, 8, 1'b1, 16'h0010);
        wait_idle();
        check("after_reset_beats", beats_seen - b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx.md
UDP_TX -- requirements
Module: udp_tx

Interface
REQ-001 Parameter P_SRC_PORT, default 16'd8080, power-up UDP source port.
REQ-002 Parameter P_DST_PORT, default 16'd8080, power-up UDP destination port.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- i_clk  in  1  sole clock; all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_dynamic_src_port  in  16  new source port
- i_dynamic_src_valid  in  1  one-cycle strobe; load i_dynamic_src_port
- i_dynamic_dst_port  in  16  new destination port
- i_dynamic_dst_valid  in  1  one-cycle strobe; load i_dynamic_dst_port
- s_axis_user_data  in  64  application payload, byte 0 in [63:56]
- s_axis_user_user  in  16  payload length in bytes; valid on first beat
- s_axis_user_keep  in  8  byte enables, MSB-aligned, contiguous
- s_axis_user_last  in  1  last payload beat
- s_axis_user_valid  in  1  payload beat valid
- s_axis_user_ready  out  1  payload beat accepted when valid&ready
- m_axis_ip_data  out  64  UDP datagram beat to IP_TX
- m_axis_ip_user  out  56  {16 len, 3 flag, 8 type, 13 offset, 16 ID}
- m_axis_ip_keep  out  8  byte enables
- m_axis_ip_last  out  1  last datagram beat
- m_axis_ip_valid  out  1  datagram beat valid
- m_axis_ip_ready  in  1  IP_TX ready
- o_drop_pulse  out  1  one-cycle pulse per dropped datagram
- o_len_err  out  1  one-cycle pulse on length/last mismatch

Function
REQ-004 States SHALL be IDLE, HEAD, DATA, DROP; reset state IDLE.
REQ-005 IDLE: s_axis_user_ready=0; on s_axis_user_valid, latch length L and current ports; 1<=L<=1472 -> HEAD, else -> DROP.
REQ-006 HEAD: one beat, data={src_port, dst_port, L+8, 16'h0000}, keep 8'hFF, last 0; -> DATA on valid&ready.
REQ-007 m_axis_ip_user SHALL be constant for the whole datagram: len=L+8, flag=3'b010, type=8'd17, offset=0, ID=current datagram ID.
REQ-008 DATA: single registered output stage; s_axis_user_ready = !m_axis_ip_valid | m_axis_ip_ready; data/keep/last copied unchanged, one-cycle latency from acceptance to m_axis_ip_valid.
REQ-009 DATA -> IDLE when the beat carrying last is accepted downstream; next datagram may start the following cycle.
REQ-010 m_axis_ip_* SHALL hold stable while valid=1 and ready=0; valid never drops without a handshake.
REQ-011 ID SHALL increment by 1 after each emitted datagram's last handshake; 16'hFFFF wraps to 16'h0000; dropped datagrams do not consume an ID.
REQ-012 DROP: s_axis_user_ready=1, nothing emitted; on last accepted, pulse o_drop_pulse, -> IDLE.
REQ-013 Length check in DATA: count accepted bytes (popcount keep); if last arrives with count!=L, or count reaches L without last, pulse o_len_err once; frame still forwarded to its input last unchanged.
REQ-014 Dynamic port strobes SHALL update port registers any cycle; a datagram uses ports latched in IDLE; mid-frame updates apply to the next datagram; src and dst strobes same cycle both load.
REQ-015 Arithmetic: L+8 computed in 16 bits; L<=1472 guarantees no overflow.

Reset
REQ-016 On i_rst: state IDLE, ID=0, ports=P_SRC_PORT/P_DST_PORT, all outputs 0 (s_axis_user_ready=0, m_axis_ip_valid=0, pulses 0).
REQ-017 Reset mid-datagram SHALL abandon the frame immediately; no partial beat re-emitted after reset; upstream must restart the frame.

Structure
REQ-018 Shared package holds state encoding, UDP protocol number 8'd17, header length 8, max payload 1472, DF flag value.
REQ-019 Single module, no sub-modules; the output register stage is inline.

Verification
REQ-020 L=16, two full beats, ready=1 -> header 1F90_1F90_0018_0000, then 2 payload beats, user len 24, type 17, ID 0, last on beat 3.
REQ-021 L=11, beats keep FF then E0 -> header len 0x0013; final keep 8'hE0, last=1; ID increments to 1.
REQ-022 m_axis_ip_ready toggled 1/0 every cycle, L=64 -> all 9 beats in order, no duplicates/losses, outputs stable while stalled.
REQ-023 L=0 and L=1500 frames -> no output, o_drop_pulse once each, input fully consumed, ID unchanged.
REQ-024 i_dynamic_dst_port=16'd5000 strobed mid-frame -> current header unchanged, next header dst=0x1388.
REQ-025 ID preset via 65535 datagrams (or forced) -> ID 16'hFFFF then 16'h0000; i_rst asserted mid-DATA -> valid=0 next cycle, ID=0.
